// File: rtl/mcp_adder_arbiter_pkg.sv
// Shared constants for the round-robin shared adder/subtractor used by the multicycle datapath.
// Saturation limits here are for the default word length; MCP_ARB_SATURATE_EN enables clamping in the top.
package mcp_adder_arbiter_pkg;

    localparam int DEFAULT_WL   = 32;
    localparam int DEFAULT_NREQ = 3;
    localparam int DEFAULT_PW   = 3;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [DEFAULT_WL-1:0] SAT_MAX = {1'b0, {(DEFAULT_WL-1){1'b1}}};
    localparam logic [DEFAULT_WL-1:0] SAT_MIN = {1'b1, {(DEFAULT_WL-1){1'b0}}};

endpackage

// File: rtl/mcp_rr_picker.sv
// Combinational round-robin picker: grants the first active request at or after ptr, wrapping.
// An out-of-range pointer is treated as pointing at index 0.
module mcp_rr_picker #(
    parameter int NREQ = 3,
    parameter int PW   = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    int   start;
    logic found;

    // Walk priority distance outward from the pointer; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        start = (int'(ptr) < NREQ) ? int'(ptr) : 0;
        for (int d = 0; d < NREQ; d++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((start + d) % NREQ) == j)) begin
                    found  = 1'b1;
                    gnt[j] = 1'b1;
                    idx    = PW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/mcp_adder_arbiter.sv
// One WL-bit add/sub unit shared round-robin among NREQ requesters, result registered one cycle after grant.
// Define MCP_ARB_SATURATE_EN to clamp Sum on signed overflow instead of wrapping.
module mcp_adder_arbiter
    import mcp_adder_arbiter_pkg::*;
#(
    parameter int WL   = DEFAULT_WL,
    parameter int NREQ = DEFAULT_NREQ,
    parameter int PW   = DEFAULT_PW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NREQ-1:0]  Req,
    input  logic [NREQ-1:0]  Sub,
    input  logic [NREQ*WL-1:0] OpA,
    input  logic [NREQ*WL-1:0] OpB,
    output logic [NREQ-1:0]  Gnt,
    output logic [NREQ-1:0]  RspValid,
    output logic [WL-1:0]    Sum,
    output logic             OVF_F,
    output logic             Busy
);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            grant_valid;
    logic [WL-1:0]   a_sel;
    logic [WL-1:0]   b_sel;
    logic            sub_sel;
    logic [WL-1:0]   b_mod;
    logic [WL-1:0]   sum_raw;
    logic [WL-1:0]   sum_final;
    logic            ovf;

    mcp_rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req (Req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign Gnt         = RST ? '0 : pick_gnt;
    assign grant_valid = |Gnt;
    assign ptr_next    = (int'(pick_idx) >= NREQ - 1) ? '0 : pick_idx + PW'(1);

    // One-hot operand mux; subtraction is A + ~B + 1 so overflow uses the inverted B sign.
    always_comb begin
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = OP_ADD;
        for (int j = 0; j < NREQ; j++) begin
            if (pick_gnt[j]) begin
                a_sel   = OpA[j*WL +: WL];
                b_sel   = OpB[j*WL +: WL];
                sub_sel = Sub[j];
            end
        end
        b_mod   = (sub_sel == OP_SUB) ? ~b_sel : b_sel;
        sum_raw = a_sel + b_mod + WL'(sub_sel);
        ovf     = (a_sel[WL-1] == b_mod[WL-1]) && (sum_raw[WL-1] != a_sel[WL-1]);
`ifdef MCP_ARB_SATURATE_EN
        if (ovf)
            sum_final = a_sel[WL-1] ? {1'b1, {(WL-1){1'b0}}} : {1'b0, {(WL-1){1'b1}}};
        else
            sum_final = sum_raw;
`else
        sum_final = sum_raw;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            RspValid <= '0;
            Sum      <= '0;
            OVF_F    <= 1'b0;
            Busy     <= 1'b0;
            ptr      <= '0;
        end else begin
            RspValid <= Gnt;
            Busy     <= grant_valid;
            if (grant_valid) begin
                Sum   <= sum_final;
                OVF_F <= ovf;
                ptr   <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_mcp_adder_arbiter.sv
// Self-checking bench for mcp_adder_arbiter: directed scenarios followed by randomized traffic against a reference model.
// Build with MCP_ARB_SATURATE_EN defined to exercise the clamping variant.
module tb_mcp_adder_arbiter;
    import mcp_adder_arbiter_pkg::*;

    localparam int WL   = DEFAULT_WL;
    localparam int NREQ = DEFAULT_NREQ;
    localparam int PW   = DEFAULT_PW;

    logic               CLK = 1'b0;
    logic               RST;
    logic [NREQ-1:0]    Req;
    logic [NREQ-1:0]    Sub;
    logic [NREQ*WL-1:0] OpA;
    logic [NREQ*WL-1:0] OpB;
    logic [NREQ-1:0]    Gnt;
    logic [NREQ-1:0]    RspValid;
    logic [WL-1:0]      Sum;
    logic               OVF_F;
    logic               Busy;

    always #5 CLK = ~CLK;

    mcp_adder_arbiter #(
        .WL   (WL),
        .NREQ (NREQ),
        .PW   (PW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Req      (Req),
        .Sub      (Sub),
        .OpA      (OpA),
        .OpB      (OpB),
        .Gnt      (Gnt),
        .RspValid (RspValid),
        .Sum      (Sum),
        .OVF_F    (OVF_F),
        .Busy     (Busy)
    );

`ifdef MCP_ARB_SATURATE_EN
    localparam logic [WL-1:0] EXP_POS_OVF = SAT_MAX;
    localparam logic [WL-1:0] EXP_NEG_OVF = SAT_MIN;
    localparam logic [WL-1:0] EXP_MIN_MIN = SAT_MIN;
`else
    localparam logic [WL-1:0] EXP_POS_OVF = 32'h8000_0000;
    localparam logic [WL-1:0] EXP_NEG_OVF = 32'h7FFF_FFFF;
    localparam logic [WL-1:0] EXP_MIN_MIN = 32'h0000_0000;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: priority pointer plus the expected registered outputs.
    int              m_ptr  = 0;
    int              m_g;
    logic [NREQ-1:0] m_gnt;
    logic [NREQ-1:0] m_rsp  = '0;
    logic [WL-1:0]   m_sum  = '0;
    logic            m_ovf  = 1'b0;
    logic            m_busy = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    function automatic int pickRef(input logic [NREQ-1:0] r, input int p);
        for (int d = 0; d < NREQ; d++)
            if (r[(p + d) % NREQ]) return (p + d) % NREQ;
        return -1;
    endfunction

    // Exact signed arithmetic in 64 bits; overflow is simply "result does not fit in WL bits".
    task automatic arithRef(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic sub,
                            output logic [WL-1:0] s, output logic o);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = (sub == OP_SUB) ? sa - sb : sa + sb;
        o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        s  = r[WL-1:0];
`ifdef MCP_ARB_SATURATE_EN
        if (o) s = (r > 0) ? SAT_MAX : SAT_MIN;
`endif
    endtask

    function automatic logic [NREQ*WL-1:0] pack3(input logic [WL-1:0] v0, input logic [WL-1:0] v1,
                                                 input logic [WL-1:0] v2);
        return {v2, v1, v0};
    endfunction

    function automatic logic [WL-1:0] randOperand();
        logic [WL-1:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'h7FFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    function automatic logic [NREQ*WL-1:0] randOps();
        return pack3(randOperand(), randOperand(), randOperand());
    endfunction

    // One clock cycle: drive on the falling edge, check Gnt mid-cycle, check registers after the rising edge.
    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] req, input logic [NREQ-1:0] sub,
                                 input logic [NREQ*WL-1:0] opa, input logic [NREQ*WL-1:0] opb,
                                 input string tag);
        logic [WL-1:0] s;
        logic          o;
        @(negedge CLK);
        RST = rst;
        Req = req;
        Sub = sub;
        OpA = opa;
        OpB = opb;
        m_g   = rst ? -1 : pickRef(req, m_ptr);
        m_gnt = '0;
        if (m_g >= 0) m_gnt[m_g] = 1'b1;
        #1;
        checkOutput({tag, ".gnt"}, 64'(Gnt), 64'(m_gnt));
        @(posedge CLK);
        if (rst) begin
            m_rsp  = '0;
            m_sum  = '0;
            m_ovf  = 1'b0;
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            m_rsp  = m_gnt;
            m_busy = (m_g >= 0);
            if (m_g >= 0) begin
                arithRef(opa[m_g*WL +: WL], opb[m_g*WL +: WL], sub[m_g], s, o);
                m_sum = s;
                m_ovf = o;
                m_ptr = (m_g + 1) % NREQ;
            end
        end
        #1;
        checkOutput({tag, ".rsp"},  64'(RspValid), 64'(m_rsp));
        checkOutput({tag, ".busy"}, 64'(Busy),     64'(m_busy));
        checkOutput({tag, ".sum"},  64'(Sum),      64'(m_sum));
        checkOutput({tag, ".ovf"},  64'(OVF_F),    64'(m_ovf));
    endtask

    initial begin
        logic [NREQ*WL-1:0] zeros;
        zeros = '0;
        RST = 1'b1;
        Req = '0;
        Sub = '0;
        OpA = '0;
        OpB = '0;

        // Reset held with every requester asserting: no grants, registers cleared.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 3'b111, 3'b000, randOps(), randOps(), "reset");
        applyStimulus(1'b0, 3'b000, 3'b000, zeros, zeros, "idle");
        applyStimulus(1'b0, 3'b111, 3'b000, randOps(), randOps(), "first");
        checkOutput("first.lit_rsp", 64'(RspValid), 64'(3'b001));

        // Single add from requester 1.
        applyStimulus(1'b0, 3'b010, {OP_ADD, OP_ADD, OP_ADD},
                      pack3(32'd0, 32'd5, 32'd0), pack3(32'd0, 32'd7, 32'd0), "add");
        checkOutput("add.lit_sum", 64'(Sum), 64'd12);
        checkOutput("add.lit_ovf", 64'(OVF_F), 64'd0);

        // Overflow boundaries.
        applyStimulus(1'b0, 3'b001, {OP_ADD, OP_ADD, OP_ADD},
                      pack3(32'h7FFF_FFFF, 32'd0, 32'd0), pack3(32'd1, 32'd0, 32'd0), "posovf");
        checkOutput("posovf.lit_sum", 64'(Sum), 64'(EXP_POS_OVF));
        checkOutput("posovf.lit_ovf", 64'(OVF_F), 64'd1);
        applyStimulus(1'b0, 3'b100, {OP_SUB, OP_ADD, OP_ADD},
                      pack3(32'd0, 32'd0, 32'h8000_0000), pack3(32'd0, 32'd0, 32'd1), "negovf");
        checkOutput("negovf.lit_sum", 64'(Sum), 64'(EXP_NEG_OVF));
        checkOutput("negovf.lit_ovf", 64'(OVF_F), 64'd1);
        applyStimulus(1'b0, 3'b010, {OP_ADD, OP_ADD, OP_ADD},
                      pack3(32'd0, 32'h8000_0000, 32'd0), pack3(32'd0, 32'h8000_0000, 32'd0), "minmin");
        checkOutput("minmin.lit_sum", 64'(Sum), 64'(EXP_MIN_MIN));
        checkOutput("minmin.lit_ovf", 64'(OVF_F), 64'd1);
        applyStimulus(1'b0, 3'b001, {OP_ADD, OP_ADD, OP_SUB},
                      pack3(32'd3, 32'd0, 32'd0), pack3(32'd10, 32'd0, 32'd0), "subneg");
        checkOutput("subneg.lit_sum", 64'(Sum), 64'hFFFF_FFF9);

        // Round-robin under full contention, starting from a fresh pointer.
        applyStimulus(1'b1, 3'b000, 3'b000, zeros, zeros, "rrreset");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b0, 3'b111, 3'($urandom), randOps(), randOps(), "rr");

        // Pointer at 1 with only requester 0 active, then 0 and 2 competing.
        applyStimulus(1'b0, 3'b001, 3'b000, randOps(), randOps(), "skip0");
        applyStimulus(1'b0, 3'b001, 3'b000, randOps(), randOps(), "skip1");
        applyStimulus(1'b0, 3'b101, 3'b000, randOps(), randOps(), "skip2");
        checkOutput("skip2.lit_rsp", 64'(RspValid), 64'(3'b100));

        // Reset the cycle after a grant drops the pending response and rewinds the pointer.
        applyStimulus(1'b0, 3'b111, 3'b000, randOps(), randOps(), "midop");
        applyStimulus(1'b1, 3'b111, 3'b000, randOps(), randOps(), "midrst");
        applyStimulus(1'b0, 3'b111, 3'b000, randOps(), randOps(), "after");

        // Randomized traffic with occasional resets and withdrawn requests.
        for (int i = 0; i < 200; i++)
            applyStimulus($urandom_range(0, 39) == 0, 3'($urandom), 3'($urandom),
                          randOps(), randOps(), "rand");

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
